// File: rtl/ecc_enc_arbiter.sv
// Two-port arbiter sharing one 32->38 Hamming SEC encoder, with a registered, backpressured output.
// Define ECC_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module ecc_enc_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CODE_W = 38,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_src,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    // Codeword bits (0-based index i) whose 1-based position i+1 has bit k set.
    function automatic logic [CODE_W-1:0] pos_mask(input int k);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(CODE_W); i++) begin
            if ((((i + 1) >> k) & 1) != 0) m = m | (CODE_W'(1) << i);
        end
        return m;
    endfunction

    function automatic logic [CODE_W-1:0] hamming_enc(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic [5:0]        p;
        c = {d[31:26], 1'b0, d[25:11], 1'b0, d[10:4], 1'b0, d[3:1], 1'b0, d[0], 2'b00};
        p = '0;
        for (int k = 0; k < 6; k++) begin
            if (^(c & pos_mask(k))) p = p | (6'(1) << k);
        end
        return {d[31:26], p[5], d[25:11], p[4], d[10:4], p[3], d[3:1], p[2], d[0], p[1], p[0]};
    endfunction

    logic              out_valid_q, out_valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              src_q, src_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;
    logic              last_q, last_d;

    logic accept;
    logic tie_pick0;
    logic grant0, grant1;

    always_comb begin
        accept = !out_valid_q || out_ready;
`ifdef ECC_ARB_RR_EN
        tie_pick0 = last_q;
`else
        tie_pick0 = 1'b1;
`endif
        grant0 = rst_n && accept && req0_valid && (!req1_valid || tie_pick0);
        grant1 = rst_n && accept && req1_valid && (!req0_valid || !tie_pick0);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        out_valid_d = out_valid_q;
        code_d      = code_q;
        src_d       = src_q;
        tag_d       = tag_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        last_d      = last_q;
        if (grant0 || grant1) begin
            out_valid_d = 1'b1;
            code_d      = hamming_enc(grant1 ? req1_data : req0_data);
            src_d       = grant1;
            tag_d       = grant1 ? req1_tag : req0_tag;
            last_d      = grant1;
            if (grant0 && cnt0_q != '1) cnt0_d = cnt0_q + 1'b1;
            if (grant1 && cnt1_q != '1) cnt1_d = cnt1_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            code_q      <= '0;
            src_q       <= 1'b0;
            tag_q       <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            last_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            src_q       <= src_d;
            tag_q       <= tag_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            last_q      <= last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_code   = code_q;
    assign out_src    = src_q;
    assign out_tag    = tag_q;
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_ecc_enc_arbiter.sv
// Self-checking bench for ecc_enc_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_ecc_enc_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [3:0]  req0_tag, req1_tag;
    logic        out_valid, out_ready, out_src;
    logic [37:0] out_code;
    logic [3:0]  out_tag;
    logic [15:0] grant_cnt0, grant_cnt1;

    ecc_enc_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_tag   (req1_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_src    (out_src),
        .out_tag    (out_tag),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_valid;
    logic [37:0] m_code;
    bit          m_src;
    logic [3:0]  m_tag;
    int          m_cnt0, m_cnt1;
    bit          m_last;
    bit          m_g0, m_g1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hamming encode: place data in non-power-of-two positions, then set each parity bit so the
    // XOR of the positions of all set bits (the syndrome) is zero.
    function automatic logic [37:0] ref_enc(input logic [31:0] d);
        logic [37:0] c;
        int          syn;
        int          di;
        c   = '0;
        syn = 0;
        di  = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (((d >> di) & 32'd1) != 0) begin
                    c   = c | (38'd1 << (pos - 1));
                    syn = syn ^ pos;
                end
                di++;
            end
        end
        for (int j = 0; j < 6; j++) begin
            if (((syn >> j) & 1) != 0) c = c | (38'd1 << ((1 << j) - 1));
        end
        return c;
    endfunction

    function automatic void model_grant();
        bit acc;
        m_g0 = 0;
        m_g1 = 0;
        acc  = !m_valid || out_ready;
        if (rst_n && acc) begin
            if (req0_valid && req1_valid) begin
`ifdef ECC_ARB_RR_EN
                if (m_last) m_g0 = 1; else m_g1 = 1;
`else
                m_g0 = 1;
`endif
            end else begin
                m_g0 = req0_valid;
                m_g1 = req1_valid;
            end
        end
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            m_valid = 0; m_code = '0; m_src = 0; m_tag = '0;
            m_cnt0 = 0; m_cnt1 = 0; m_last = 1;
        end else if (m_g0 || m_g1) begin
            m_valid = 1;
            m_src   = m_g1;
            m_last  = m_g1;
            m_code  = ref_enc(m_g1 ? req1_data : req0_data);
            m_tag   = m_g1 ? req1_tag : req0_tag;
            if (m_g0 && m_cnt0 < 65535) m_cnt0++;
            if (m_g1 && m_cnt1 < 65535) m_cnt1++;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endfunction

    // One clock: check readies for the current inputs, advance, check registered outputs.
    task automatic cycle(input bit chk);
        #1;
        model_grant();
        if (chk) begin
            check_val("req0_ready", 64'(req0_ready), 64'(m_g0));
            check_val("req1_ready", 64'(req1_ready), 64'(m_g1));
        end
        @(posedge clk);
        model_edge();
        #1;
        if (chk) begin
            check_val("out_valid", 64'(out_valid), 64'(m_valid));
            check_val("out_code", 64'(out_code), 64'(m_code));
            check_val("out_src", 64'(out_src), 64'(m_src));
            check_val("out_tag", 64'(out_tag), 64'(m_tag));
            check_val("grant_cnt0", 64'(grant_cnt0), 64'(m_cnt0));
            check_val("grant_cnt1", 64'(grant_cnt1), 64'(m_cnt1));
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        req0_valid = 0; req1_valid = 0; out_ready = 0;
        cycle(1);
        cycle(1);
        rst_n = 1;
    endtask

    initial begin
        req0_data = '0; req1_data = '0; req0_tag = '0; req1_tag = '0;
        do_reset();

        // Single word through port 0
        req0_valid = 1; req0_data = 32'h1; req0_tag = 4'h5; out_ready = 1;
        cycle(1);
        req0_valid = 0;
        check_val("single_code", 64'(out_code), 64'h7);
        check_val("single_src", 64'(out_src), 64'd0);
        check_val("single_tag", 64'(out_tag), 64'h5);
        check_val("single_cnt0", 64'(grant_cnt0), 64'd1);

        // Encode vectors through port 1
        req1_valid = 1; req1_data = 32'h0; req1_tag = 4'h2;
        cycle(1);
        check_val("enc_zero", 64'(out_code), 64'h0);
        check_val("enc_zero_src", 64'(out_src), 64'd1);
        req1_data = 32'hFFFF_FFFF;
        cycle(1);
        check_val("enc_ones", 64'(out_code), 64'(ref_enc(32'hFFFF_FFFF)));
        check_val("enc_ones_src", 64'(out_src), 64'd1);
        req1_valid = 0;
        cycle(1);

        // Contention from reset
        do_reset();
        req0_valid = 1; req1_valid = 1; out_ready = 1;
        req0_data = 32'hA5A5_0001; req1_data = 32'h5A5A_0002; req0_tag = 4'h3; req1_tag = 4'hC;
        for (int i = 0; i < 6; i++) begin
            cycle(1);
`ifdef ECC_ARB_RR_EN
            check_val("cont_src", 64'(out_src), 64'(i % 2));
`else
            check_val("cont_src", 64'(out_src), 64'd0);
`endif
        end
`ifdef ECC_ARB_RR_EN
        check_val("cont_cnt0", 64'(grant_cnt0), 64'd3);
        check_val("cont_cnt1", 64'(grant_cnt1), 64'd3);
`else
        check_val("cont_cnt0", 64'(grant_cnt0), 64'd6);
        check_val("cont_cnt1", 64'(grant_cnt1), 64'd0);
`endif

        // Backpressure: stall 3 cycles with both requesting, then drain+reload
        out_ready = 0;
        for (int i = 0; i < 3; i++) cycle(1);
        out_ready = 1;
        cycle(1);

        // Reset mid-stall
        out_ready = 0;
        cycle(1);
        rst_n = 0;
        cycle(1);
        check_val("mid_rst_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_cnt0", 64'(grant_cnt0), 64'd0);
        rst_n = 1; out_ready = 1;
        cycle(1);
        check_val("mid_rst_tie", 64'(out_src), 64'd0);

        // Saturation of port 0 counter
        do_reset();
        req1_valid = 0; req0_valid = 1; out_ready = 1;
        for (int i = 0; i < 65535; i++) cycle(0);
        check_val("sat_pre", 64'(grant_cnt0), 64'hFFFF);
        req0_data = 32'h1234_5678; req0_tag = 4'h9;
        cycle(1);
        check_val("sat_cnt0", 64'(grant_cnt0), 64'hFFFF);
        check_val("sat_code", 64'(out_code), 64'(ref_enc(32'h1234_5678)));

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_data  = $urandom;
            req1_data  = $urandom;
            req0_tag   = 4'($urandom);
            req1_tag   = 4'($urandom);
            out_ready  = ($urandom_range(0, 9) < 7);
            cycle(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
